// File: rtl/stage_fetch.sv
// Instruction fetch stage: owns the PC, issues Wishbone-classic reads and hands
// instructions to decode through a registered output slot backed by a one-entry skid.
module stage_fetch #(
    parameter logic [31:0] RESET_ADDR = 32'h8000_0000,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] iwbm_addr_o,
    output logic        iwbm_cyc_o,
    output logic        iwbm_stb_o,
    input  logic [31:0] iwbm_dat_i,
    input  logic        iwbm_ack_i,
    input  logic        iwbm_err_i,
    input  logic        is_br_j_taken_i,
    input  logic [31:0] br_j_addr_i,
    input  logic        trap_i,
    input  logic [31:0] trap_addr_i,
    input  logic        stall_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        valid_o,
    output logic        e_inst_access_fault_o,
    output logic [2:0]  dbg_state_o
);

    // Handshake: a bus beat completes on an edge where cyc&stb&(ack|err); the
    // output slot drains on an edge where valid_o=1 and stall_i=0.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_HOLD  = 3'd2,
        S_DROP  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t      r_state;
    logic [31:0] r_addr;
    logic [31:0] r_target;
    logic        r_cyc;

    logic [31:0] r_inst;
    logic [31:0] r_pc_out;
    logic        r_valid;
    logic        r_fault;

    logic [31:0] r_skid_inst;
    logic [31:0] r_skid_pc;
    logic        r_skid_fault;
    logic        r_skid_valid;

    logic        w_done;
    logic        w_err;
    logic        w_ack;
    logic        w_redirect;
    logic [31:0] w_target;
    logic        w_drain;
    logic        w_slot_free;
    logic [31:0] w_addr_next;

    assign w_done      = r_cyc & (iwbm_ack_i | iwbm_err_i);
    assign w_err       = w_done & iwbm_err_i;
    assign w_ack       = w_done & ~iwbm_err_i;
    assign w_redirect  = trap_i | is_br_j_taken_i;
    assign w_target    = trap_i ? {trap_addr_i[31:2], 2'b00} : {br_j_addr_i[31:2], 2'b00};
    assign w_drain     = r_valid & ~stall_i;
    assign w_slot_free = ~r_valid | ~stall_i;
    assign w_addr_next = r_addr + 32'd4;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_addr       <= RESET_ADDR;
            r_target     <= RESET_ADDR;
            r_cyc        <= 1'b0;
            r_inst       <= NOP_INST;
            r_pc_out     <= 32'd0;
            r_valid      <= 1'b0;
            r_fault      <= 1'b0;
            r_skid_inst  <= NOP_INST;
            r_skid_pc    <= 32'd0;
            r_skid_fault <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_redirect) begin
            r_valid      <= 1'b0;
            r_fault      <= 1'b0;
            r_inst       <= NOP_INST;
            r_skid_valid <= 1'b0;
            r_skid_fault <= 1'b0;
            r_target     <= w_target;
            // An outstanding beat must finish on its old address before retargeting.
            if (r_cyc && !w_done) begin
                r_state <= S_DROP;
            end else begin
                r_state <= S_FETCH;
                r_addr  <= w_target;
                r_cyc   <= 1'b1;
            end
        end else begin
            if (w_drain) begin
                r_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    r_state <= S_FETCH;
                    r_cyc   <= 1'b1;
                end
                S_FETCH: begin
                    if (w_err) begin
                        r_state <= S_FAULT;
                        r_cyc   <= 1'b0;
                        if (w_slot_free) begin
                            r_valid  <= 1'b1;
                            r_inst   <= NOP_INST;
                            r_pc_out <= r_addr;
                            r_fault  <= 1'b1;
                        end else begin
                            r_skid_valid <= 1'b1;
                            r_skid_inst  <= NOP_INST;
                            r_skid_pc    <= r_addr;
                            r_skid_fault <= 1'b1;
                        end
                    end else if (w_ack) begin
                        r_addr <= w_addr_next;
                        if (w_slot_free) begin
                            r_valid  <= 1'b1;
                            r_inst   <= iwbm_dat_i;
                            r_pc_out <= r_addr;
                            r_fault  <= 1'b0;
                        end else begin
                            r_skid_valid <= 1'b1;
                            r_skid_inst  <= iwbm_dat_i;
                            r_skid_pc    <= r_addr;
                            r_skid_fault <= 1'b0;
                            r_state      <= S_HOLD;
                            r_cyc        <= 1'b0;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_drain) begin
                        r_valid      <= 1'b1;
                        r_inst       <= r_skid_inst;
                        r_pc_out     <= r_skid_pc;
                        r_fault      <= r_skid_fault;
                        r_skid_valid <= 1'b0;
                        r_state      <= S_FETCH;
                        r_cyc        <= 1'b1;
                    end
                end
                S_DROP: begin
                    if (w_done) begin
                        r_state <= S_FETCH;
                        r_addr  <= r_target;
                    end
                end
                S_FAULT: begin
                    // A fault recorded while decode was stalled waits in the skid.
                    if (w_drain && r_skid_valid) begin
                        r_valid      <= 1'b1;
                        r_inst       <= r_skid_inst;
                        r_pc_out     <= r_skid_pc;
                        r_fault      <= r_skid_fault;
                        r_skid_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cyc   <= 1'b0;
                end
            endcase
        end
    end

    assign iwbm_addr_o           = r_addr;
    assign iwbm_cyc_o            = r_cyc;
    assign iwbm_stb_o            = r_cyc;
    assign inst_o                = r_inst;
    assign pc_o                  = r_pc_out;
    assign valid_o               = r_valid;
    assign e_inst_access_fault_o = r_fault;
    assign dbg_state_o           = r_state;

endmodule
